pmu_hpm: RTL and testbench

PMU_HPM -- requirements
Module: pmu_hpm

---
 rtl/pmu_pkg.sv | 37 +++
 rtl/pmu_counter.sv | 34 +++
 rtl/pmu_hpm.sv | 132 +++++++++++++
 tb/tb_pmu_hpm.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// pmu_pkg: shared constants for the hardware performance monitor.
//   CSR addresses, mhpmevent field layout, mcountinhibit bit indices and
//   small address/mask helpers used by pmu_hpm.
package pmu_pkg;

  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MHPMCNT3  = 12'hB03;
  localparam logic [11:0] CSR_HI_OFS    = 12'h080;  // *H alias offset
  localparam logic [11:0] CSR_MCOUNTINH = 12'h320;
  localparam logic [11:0] CSR_MHPMEVT3  = 12'h323;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int SEL_W    = 8;   // mhpmevent[7:0] event select
  localparam int OF_BIT   = 31;  // mhpmevent[XLEN-1] sticky overflow
  localparam int INH_CY   = 0;
  localparam int INH_IR   = 2;
  localparam int INH_HPM3 = 3;

  // Counter slot k: 0 = mcycle, 1 = minstret, 2.. = mhpmcounter3..
  function automatic logic [11:0] cnt_addr(input int k);
    if (k == 0)      return CSR_MCYCLE;
    else if (k == 1) return CSR_MINSTRET;
    else             return CSR_MHPMCNT3 + 12'(k - 2);
  endfunction

  // Writable mcountinhibit bits: CY, IR and one per programmable counter.
  function automatic logic [31:0] inh_mask(input int n);
    logic [31:0] m;
    m = '0;
    m[INH_CY] = 1'b1;
    m[INH_IR] = 1'b1;
    for (int i = 0; i < n; i++) m[INH_HPM3+i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pmu_counter.sv
// pmu_counter: one W-bit performance counter with 32-bit CSR write halves.
//   i_clk/i_rst  : clock, synchronous active-high reset
//   i_wr_lo      : load bits [31:0] from i_wdata (upper bits hold)
//   i_wr_hi      : load bits [W-1:32] from i_wdata (lower bits hold)
//   i_inc        : count by one when no write is present
//   o_value      : current count
//   o_wrap       : this edge increments from all-ones to zero
module pmu_counter #(
  parameter int W = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_lo,
  input  logic          i_wr_hi,
  input  logic [31:0]   i_wdata,
  input  logic          i_inc,
  output logic [W-1:0]  o_value,
  output logic          o_wrap
);

  logic [W-1:0] r_val;

  // A write to either half wins over the increment, so no wrap then.
  assign o_wrap  = i_inc & ~i_wr_lo & ~i_wr_hi & (&r_val);
  assign o_value = r_val;

  always_ff @(posedge i_clk) begin
    if (i_rst)        r_val <= '0;
    else if (i_wr_lo) r_val[31:0] <= i_wdata;
    else if (i_wr_hi) r_val[W-1:32] <= i_wdata[W-33:0];
    else if (i_inc)   r_val <= r_val + W'(1);
  end

endmodule

// File: rtl/pmu_hpm.sv
// pmu_hpm: machine-mode hardware performance monitor.
//   clk_free/rst        : free-running clock, synchronous active-high reset
//   cpu_id              : hart id, registered into mhartid every cycle
//   inst_valid          : instruction retired this cycle (minstret)
//   evt                 : per-cycle event pulses selectable by mhpmevent
//   csr_wr/waddr/wdata  : CSR write port (takes effect at the clock edge)
//   csr_raddr/rdata     : combinational CSR read port
//   irq_ovf             : registered OR of all mhpmevent OF bits
module pmu_hpm
  import pmu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_CNT = 4,
  parameter int CNT_W   = 64,
  parameter int NUM_EVT = 16
) (
  input  logic               clk_free,
  input  logic               rst,
  input  logic [XLEN-1:0]    cpu_id,
  input  logic               inst_valid,
  input  logic [NUM_EVT-1:0] evt,
  input  logic               csr_wr,
  input  logic [11:0]        csr_waddr,
  input  logic [XLEN-1:0]    csr_wdata,
  input  logic [11:0]        csr_raddr,
  output logic [XLEN-1:0]    csr_rdata,
  output logic               irq_ovf
);

  localparam int NCTR = NUM_CNT + 2;
  localparam int NE   = (NUM_CNT > 0) ? NUM_CNT : 1;
  localparam logic [31:0] INH_MASK = inh_mask(NUM_CNT);

  logic [NCTR-1:0]  w_wr_lo, w_wr_hi, w_inc, w_wrap;
  logic [63:0]      w_val [NCTR];
  logic [SEL_W-1:0] r_sel [NE];
  logic [NE-1:0]    r_of;
  logic [NE-1:0]    w_hit;
  logic [31:0]      r_inh;
  logic [XLEN-1:0]  r_hartid;
  logic             r_irq;

  // Write strobes per counter half.
  always_comb begin
    w_wr_lo = '0;
    w_wr_hi = '0;
    for (int k = 0; k < NCTR; k++) begin
      w_wr_lo[k] = csr_wr && (csr_waddr == cnt_addr(k));
      w_wr_hi[k] = csr_wr && (csr_waddr == (cnt_addr(k) + CSR_HI_OFS));
    end
  end

  // Event select: SEL=k picks evt[k-1]; 0 or out-of-range matches nothing.
  always_comb begin
    w_hit = '0;
    for (int i = 0; i < NUM_CNT; i++)
      for (int e = 0; e < NUM_EVT; e++)
        if (r_sel[i] == SEL_W'(e + 1)) w_hit[i] = w_hit[i] | evt[e];
  end

  always_comb begin
    w_inc    = '0;
    w_inc[0] = ~r_inh[INH_CY];
    w_inc[1] = inst_valid & ~r_inh[INH_IR];
    for (int i = 0; i < NUM_CNT; i++)
      w_inc[2+i] = w_hit[i] & ~r_inh[INH_HPM3+i];
  end

  // mcycle/minstret are always 64 bits; programmable counters use CNT_W.
  for (genvar k = 0; k < NCTR; k++) begin : g_cnt
    localparam int CW = (k < 2) ? 64 : CNT_W;
    logic [CW-1:0] w_v;
    pmu_counter #(.W(CW)) u_cnt (
      .i_clk   (clk_free),
      .i_rst   (rst),
      .i_wr_lo (w_wr_lo[k]),
      .i_wr_hi (w_wr_hi[k]),
      .i_wdata (csr_wdata[31:0]),
      .i_inc   (w_inc[k]),
      .o_value (w_v),
      .o_wrap  (w_wrap[k])
    );
    assign w_val[k] = 64'(w_v);
  end

  // mhpmevent: an overflow on the same edge as a write keeps OF set.
  always_ff @(posedge clk_free) begin
    if (rst) begin
      for (int i = 0; i < NE; i++) r_sel[i] <= '0;
      r_of <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (csr_wr && (csr_waddr == (CSR_MHPMEVT3 + 12'(i)))) begin
          r_sel[i] <= csr_wdata[SEL_W-1:0];
          r_of[i]  <= csr_wdata[OF_BIT] | w_wrap[2+i];
        end else if (w_wrap[2+i]) begin
          r_of[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_free) begin
    if (rst) begin
      r_inh    <= '0;
      r_hartid <= '0;
      r_irq    <= 1'b0;
    end else begin
      if (csr_wr && (csr_waddr == CSR_MCOUNTINH))
        r_inh <= csr_wdata[31:0] & INH_MASK;
      r_hartid <= cpu_id;
      r_irq    <= |r_of;
    end
  end

  assign irq_ovf = r_irq;

  // Combinational read mux; anything not matched reads zero.
  always_comb begin
    csr_rdata = '0;
    for (int k = 0; k < NCTR; k++) begin
      if (csr_raddr == cnt_addr(k))                csr_rdata = w_val[k][31:0];
      if (csr_raddr == (cnt_addr(k) + CSR_HI_OFS)) csr_rdata = w_val[k][63:32];
    end
    for (int i = 0; i < NUM_CNT; i++)
      if (csr_raddr == (CSR_MHPMEVT3 + 12'(i)))
        csr_rdata = {r_of[i], {(XLEN-1-SEL_W){1'b0}}, r_sel[i]};
    if (csr_raddr == CSR_MCOUNTINH) csr_rdata = r_inh;
    if (csr_raddr == CSR_MHARTID)   csr_rdata = r_hartid;
  end

endmodule

// File: tb/tb_pmu_hpm.sv
// tb_pmu_hpm: directed scenarios plus randomized traffic checked against a
// CSR-level reference model of the performance monitor.
module tb_pmu_hpm;

  localparam int NC  = 4;
  localparam int NEV = 16;
  localparam int CW  = 40;
  localparam logic [63:0] HMASK = 64'h0000_00FF_FFFF_FFFF;

  logic            clk_free = 1'b0;
  logic            rst = 1'b1;
  logic [31:0]     cpu_id = '0;
  logic            inst_valid = 1'b0;
  logic [NEV-1:0]  evt = '0;
  logic            csr_wr = 1'b0;
  logic [11:0]     csr_waddr = '0;
  logic [31:0]     csr_wdata = '0;
  logic [11:0]     csr_raddr = '0;
  logic [31:0]     csr_rdata;
  logic            irq_ovf;

  int nchk = 0;
  int nfail = 0;

  pmu_hpm #(.XLEN(32), .NUM_CNT(NC), .CNT_W(CW), .NUM_EVT(NEV)) dut (
    .clk_free  (clk_free),
    .rst       (rst),
    .cpu_id    (cpu_id),
    .inst_valid(inst_valid),
    .evt       (evt),
    .csr_wr    (csr_wr),
    .csr_waddr (csr_waddr),
    .csr_wdata (csr_wdata),
    .csr_raddr (csr_raddr),
    .csr_rdata (csr_rdata),
    .irq_ovf   (irq_ovf)
  );

  always #10 clk_free = ~clk_free;

  // Reference model: architectural CSR state.
  logic [63:0] m_cyc, m_ins;
  logic [63:0] m_hpm [NC];
  logic [7:0]  m_sel [NC];
  bit          m_of  [NC];
  logic [31:0] m_inh, m_hart;
  bit          m_irq;

  function automatic void model_step();
    logic [63:0] nh;
    bit ovf;
    bit any_of;
    bit hit;
    if (rst) begin
      m_cyc = '0; m_ins = '0; m_inh = '0; m_hart = '0; m_irq = 0;
      for (int i = 0; i < NC; i++) begin m_hpm[i] = '0; m_sel[i] = '0; m_of[i] = 0; end
      return;
    end
    any_of = 0;
    for (int i = 0; i < NC; i++) any_of |= m_of[i];
    if (csr_wr && csr_waddr == 12'hB00)      m_cyc = {m_cyc[63:32], csr_wdata};
    else if (csr_wr && csr_waddr == 12'hB80) m_cyc = {csr_wdata, m_cyc[31:0]};
    else if (!m_inh[0])                      m_cyc = m_cyc + 1;
    if (csr_wr && csr_waddr == 12'hB02)      m_ins = {m_ins[63:32], csr_wdata};
    else if (csr_wr && csr_waddr == 12'hB82) m_ins = {csr_wdata, m_ins[31:0]};
    else if (!m_inh[2] && inst_valid)        m_ins = m_ins + 1;
    for (int i = 0; i < NC; i++) begin
      hit = (m_sel[i] >= 1 && m_sel[i] <= NEV) ? evt[m_sel[i]-1] : 1'b0;
      ovf = 0;
      nh  = m_hpm[i];
      if (csr_wr && csr_waddr == 12'(12'hB03 + i))      nh = {m_hpm[i][63:32], csr_wdata} & HMASK;
      else if (csr_wr && csr_waddr == 12'(12'hB83 + i)) nh = {csr_wdata, m_hpm[i][31:0]} & HMASK;
      else if (hit && !m_inh[3+i]) begin
        if (m_hpm[i] == HMASK) begin nh = '0; ovf = 1; end
        else nh = m_hpm[i] + 1;
      end
      m_hpm[i] = nh;
      if (csr_wr && csr_waddr == 12'(12'h323 + i)) begin
        m_sel[i] = csr_wdata[7:0];
        m_of[i]  = csr_wdata[31] | ovf;
      end else if (ovf) m_of[i] = 1;
    end
    if (csr_wr && csr_waddr == 12'h320) m_inh = csr_wdata & 32'h0000_007D;
    m_hart = cpu_id;
    m_irq  = any_of;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    if (a == 12'hB00) return m_cyc[31:0];
    if (a == 12'hB80) return m_cyc[63:32];
    if (a == 12'hB02) return m_ins[31:0];
    if (a == 12'hB82) return m_ins[63:32];
    if (a >= 12'hB03 && a < 12'hB03 + NC) return m_hpm[a-12'hB03][31:0];
    if (a >= 12'hB83 && a < 12'hB83 + NC) return m_hpm[a-12'hB83][63:32];
    if (a >= 12'h323 && a < 12'h323 + NC) return {m_of[a-12'h323], 23'b0, m_sel[a-12'h323]};
    if (a == 12'h320) return m_inh;
    if (a == 12'hF14) return m_hart;
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk_free);
    model_step();
    #1;
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    csr_raddr = a;
    #1;
    d = csr_rdata;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    csr_wr = 1'b1; csr_waddr = a; csr_wdata = d;
    tick();
    csr_wr = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [11:0] al [6] = '{12'hB00, 12'hB02, 12'hB03, 12'h323, 12'h320, 12'hF14};
    rst = 1'b1; evt = '1; inst_valid = 1'b1; cpu_id = 32'hABCD;
    csr_wr = 1'b1; csr_waddr = 12'hB00; csr_wdata = 32'h55;
    tick(); tick();
    csr_wr = 1'b0; evt = '0; inst_valid = 1'b0;
    foreach (al[j]) begin
      rd(al[j], d);
      nchk++;
      if (d !== 32'h0) begin nfail++; $display("FAIL reset_rd %h: got %h expected 0", al[j], d); end
    end
    nchk++;
    if (irq_ovf !== 1'b0) begin nfail++; $display("FAIL reset_irq: got %b expected 0", irq_ovf); end
  endtask

  task automatic test_idle();
    logic [31:0] d;
    rst = 1'b0; cpu_id = '0;
    repeat (10) tick();
    rd(12'hB00, d); nchk++;
    if (d !== 32'd10) begin nfail++; $display("FAIL idle_mcycle: got %0d expected 10", d); end
    rd(12'hB02, d); nchk++;
    if (d !== 32'd0) begin nfail++; $display("FAIL idle_minstret: got %0d expected 0", d); end
    rd(12'h323, d); nchk++;
    if (d !== 32'd0) begin nfail++; $display("FAIL idle_mhpmevent3: got %h expected 0", d); end
    nchk++;
    if (irq_ovf !== 1'b0) begin nfail++; $display("FAIL idle_irq: got %b expected 0", irq_ovf); end
  endtask

  task automatic test_event_count();
    logic [31:0] d;
    wr(12'h323, 32'h3);
    evt = 16'h0004; repeat (5) tick(); evt = '0;
    rd(12'hB03, d); nchk++;
    if (d !== 32'd5) begin nfail++; $display("FAIL evt_count: got %0d expected 5", d); end
    wr(12'h320, 32'h8);
    evt = 16'h0004; repeat (5) tick(); evt = '0;
    rd(12'hB03, d); nchk++;
    if (d !== 32'd5) begin nfail++; $display("FAIL evt_inhibit: got %0d expected 5", d); end
    wr(12'h320, 32'h0);
    wr(12'h323, 32'd17);
    evt = '1; repeat (3) tick(); evt = '0;
    rd(12'hB03, d); nchk++;
    if (d !== 32'd5) begin nfail++; $display("FAIL evt_sel_range: got %0d expected 5", d); end
    wr(12'h320, 32'hFFFF_FFFF);
    rd(12'h320, d); nchk++;
    if (d !== 32'h7D) begin nfail++; $display("FAIL inh_mask: got %h expected 0000007d", d); end
    wr(12'h320, 32'h0);
    wr(12'h323, 32'h3);
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'hFFFF_FFFF);
    rd(12'hB83, d); nchk++;
    if (d !== 32'hFF) begin nfail++; $display("FAIL ovf_hi_trunc: got %h expected 000000ff", d); end
    evt = 16'h0004; tick(); evt = '0;
    rd(12'hB03, d); nchk++;
    if (d !== 32'h0) begin nfail++; $display("FAIL ovf_wrap_lo: got %h expected 0", d); end
    rd(12'hB83, d); nchk++;
    if (d !== 32'h0) begin nfail++; $display("FAIL ovf_wrap_hi: got %h expected 0", d); end
    rd(12'h323, d); nchk++;
    if (d !== 32'h8000_0003) begin nfail++; $display("FAIL ovf_of_bit: got %h expected 80000003", d); end
    nchk++;
    if (irq_ovf !== 1'b0) begin nfail++; $display("FAIL ovf_irq_latency: got %b expected 0", irq_ovf); end
    tick(); nchk++;
    if (irq_ovf !== 1'b1) begin nfail++; $display("FAIL ovf_irq_set: got %b expected 1", irq_ovf); end
    wr(12'h323, 32'h3);
    rd(12'h323, d); nchk++;
    if (d !== 32'h3) begin nfail++; $display("FAIL ovf_of_clear: got %h expected 00000003", d); end
    tick(); nchk++;
    if (irq_ovf !== 1'b0) begin nfail++; $display("FAIL ovf_irq_clear: got %b expected 0", irq_ovf); end
  endtask

  task automatic test_write_priority();
    logic [31:0] d, lo_before;
    lo_before = m_cyc[31:0];
    wr(12'hB80, 32'h1234_5678);
    rd(12'hB00, d); nchk++;
    if (d !== lo_before) begin nfail++; $display("FAIL wrhi_lo_hold: got %h expected %h", d, lo_before); end
    wr(12'hB00, 32'h100);
    rd(12'hB00, d); nchk++;
    if (d !== 32'h100) begin nfail++; $display("FAIL wrlo_value: got %h expected 00000100", d); end
    tick();
    rd(12'hB00, d); nchk++;
    if (d !== 32'h101) begin nfail++; $display("FAIL wrlo_next: got %h expected 00000101", d); end
    rd(12'hB80, d); nchk++;
    if (d !== 32'h1234_5678) begin nfail++; $display("FAIL wrlo_hi_hold: got %h expected 12345678", d); end
  endtask

  task automatic test_of_collision();
    logic [31:0] d;
    wr(12'hB03, 32'hFFFF_FFFF);
    wr(12'hB83, 32'h0000_00FF);
    csr_wr = 1'b1; csr_waddr = 12'h323; csr_wdata = 32'h3; evt = 16'h0004;
    tick();
    csr_wr = 1'b0; evt = '0;
    rd(12'h323, d); nchk++;
    if (d !== 32'h8000_0003) begin nfail++; $display("FAIL collide_of: got %h expected 80000003", d); end
    rd(12'hB03, d); nchk++;
    if (d !== 32'h0) begin nfail++; $display("FAIL collide_cnt: got %h expected 0", d); end
    tick(); nchk++;
    if (irq_ovf !== 1'b1) begin nfail++; $display("FAIL collide_irq: got %b expected 1", irq_ovf); end
    wr(12'h323, 32'h3);
    tick();
  endtask

  task automatic test_unmapped();
    logic [31:0] d;
    logic [11:0] al [4] = '{12'hB07, 12'hB87, 12'h327, 12'hB01};
    cpu_id = 32'h5;
    wr(12'hB07, 32'h1234);
    wr(12'h327, 32'h8000_00FF);
    wr(12'hF14, 32'hDEAD);
    foreach (al[j]) begin
      rd(al[j], d); nchk++;
      if (d !== 32'h0) begin nfail++; $display("FAIL unmapped %h: got %h expected 0", al[j], d); end
    end
    rd(12'hF14, d); nchk++;
    if (d !== 32'h5) begin nfail++; $display("FAIL mhartid: got %h expected 00000005", d); end
  endtask

  task automatic test_random();
    logic [31:0] d, e;
    logic [11:0] a;
    logic [11:0] al [21] = '{12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hB03, 12'hB04, 12'hB05,
                             12'hB06, 12'hB83, 12'hB84, 12'hB85, 12'hB86, 12'h323, 12'h324,
                             12'h325, 12'h326, 12'h320, 12'hF14, 12'hB07, 12'h327, 12'hB01};
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 99) == 0);
      evt        = NEV'($urandom());
      inst_valid = $urandom_range(0, 1) == 1;
      cpu_id     = $urandom();
      csr_wr     = ($urandom_range(0, 2) == 0);
      csr_waddr  = al[$urandom_range(0, 20)];
      case ($urandom_range(0, 3))
        0: csr_wdata = $urandom();
        1: csr_wdata = 32'hFFFF_FFFF;
        2: csr_wdata = 32'hFFFF_FFF0;
        default: csr_wdata = {1'($urandom()), 23'b0, 8'($urandom_range(0, 20))};
      endcase
      if (csr_waddr == 12'h320) csr_wdata = csr_wdata & 32'h7D & 32'($urandom());
      tick();
      a = al[$urandom_range(0, 20)];
      rd(a, d);
      e = m_read(a);
      nchk++;
      if (d !== e) begin nfail++; $display("FAIL rand_read %h cyc %0d: got %h expected %h", a, c, d, e); end
      nchk++;
      if (irq_ovf !== m_irq) begin nfail++; $display("FAIL rand_irq cyc %0d: got %b expected %b", c, irq_ovf, m_irq); end
    end
    rst = 1'b0; csr_wr = 1'b0; evt = '0; inst_valid = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    evt = '1; inst_valid = 1'b1;
    repeat (5) tick();
    rst = 1'b1; csr_wr = 1'b1; csr_waddr = 12'hB00; csr_wdata = 32'h55;
    tick();
    rst = 1'b0; csr_wr = 1'b0; evt = '0; inst_valid = 1'b0;
    rd(12'hB00, d); nchk++;
    if (d !== 32'h0) begin nfail++; $display("FAIL midrst_mcycle: got %h expected 0", d); end
    rd(12'hB02, d); nchk++;
    if (d !== 32'h0) begin nfail++; $display("FAIL midrst_minstret: got %h expected 0", d); end
    tick();
    rd(12'hB00, d); nchk++;
    if (d !== 32'h1) begin nfail++; $display("FAIL midrst_first_inc: got %h expected 1", d); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_event_count();
    test_overflow();
    test_write_priority();
    test_of_collision();
    test_unmapped();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
